mem_access_sequencer: RTL and testbench
=======================================

// Module: mem_access_sequencer
// PURPOSE
//  Sequences every CPU access to the single-port main memory and shares it between two requesters:
//  the instruction-fetch port (drives MAR from PC) and the load/store data port.
//  Runs each transaction as address setup, a strobe window of LAT cycles, then capture with a one-cycle ack.
//  Sits between the control unit and the RAM; the control unit holds a request until it sees the ack.
// PARAMETERS
//  AW           9   memory word-address width
//  LAT          2   cycles mem_rd/mem_wr held high before mem_rdata is valid (>=1)
//  MAX_D_STREAK 4   consecutive data grants allowed while if_req is pending before fetch is forced
// PORTS
//  clock     in   1   rising-edge clock
//  reset     in   1   synchronous, active-high
//  if_req    in   1   fetch request, held until if_ack
//  if_addr   in   AW  fetch address, sampled at grant
//  if_ack    out  1   one-cycle fetch completion pulse
//  if_rdata  out  32  fetched word, valid from if_ack onward
//  d_req     in   1   data request, held until d_ack
//  d_we      in   1   1 = store, 0 = load, sampled at grant
//  d_addr    in   AW  data address, sampled at grant
//  d_wdata   in   32  store data, sampled at grant
//  d_ack     out  1   one-cycle data completion pulse
//  d_rdata   out  32  loaded word, valid from d_ack onward
//  mem_addr  out  AW  RAM address
//  mem_wdata out  32  RAM write data
//  mem_rd    out  1   RAM read strobe
//  mem_wr    out  1   RAM write strobe
//  mem_rdata in   32  RAM read data
//  busy      out  1   high in every state except IDLE
// BEHAVIOUR
//  Interface: reset is synchronous, active-high; clock is the rising-edge clock.
//  Reset: state=IDLE, streak=0, every output 0, including rdata registers and mem_addr.
//  FSM: IDLE -> SETUP -> ACCESS (LAT cycles, down-counter) -> DONE -> IDLE.
//  IDLE: grant decided on requests sampled this cycle. Priority is d_req, except fetch wins when
//    if_req=1 and streak==MAX_D_STREAK. No request means stay in IDLE.
//  Grant edge: latch owner, addr, we and wdata. Later changes on requester inputs are ignored.
//  Streak: +1 on a data grant while if_req=1 (saturates at MAX_D_STREAK).
//    Cleared on any fetch grant, or on a data grant while if_req=0.
//  SETUP (1 cycle): mem_addr/mem_wdata driven from latches; strobes 0.
//  ACCESS (LAT cycles): mem_rd=~we or mem_wr=we; mem_addr and mem_wdata are stable.
//  DONE (1 cycle): strobes 0; owner's ack=1.
//    On a read, owner's rdata <= mem_rdata at the edge entering DONE, so it is valid in the ack cycle.
//    A store leaves d_rdata unchanged.
//  Latency: request high in IDLE at cycle 0 -> SETUP at 1, ACCESS at 2..LAT+1, ack at LAT+2, IDLE at LAT+3.
//    Back-to-back throughput is one transaction per LAT+3 cycles.
//  rdata outputs hold until the next completed read on the same port.
//  mem_addr/mem_wdata keep their last value while in IDLE.
//  Handshake: the requester drops req on the edge ending its ack cycle. req still high in IDLE is a new request.
//  req dropped mid-transaction: the transaction still completes and ack is still pulsed.
//  Simultaneous if_req and d_req: exactly one grant. The loser stays pending, is never lost, and gets no ack.
//  Reset mid-transaction: abort. The next cycle is IDLE with strobes 0, no ack, and streak=0.
//  At most one of mem_rd, mem_wr, if_ack, d_ack is high in any cycle.
// TESTING
//  Single fetch, LAT=2, RAM[0x010]=0xDEADBEEF, if_req@0 -> mem_rd high cycles 2-3; if_ack@4; if_rdata=0xDEADBEEF.
//  Store d_addr=0x020, d_wdata=0x12345678 -> mem_wr high 2 cycles with addr 0x020; d_ack@4; d_rdata unchanged.
//  if_req and d_req both high at cycle 0 -> data served first (d_ack@4); fetch granted in IDLE@5, if_ack@9.
//  if_req held, d_req re-raised after every ack -> exactly 4 data acks, then 1 fetch ack, pattern repeats.
//  Reset asserted during ACCESS of a load -> strobes 0 next cycle, no d_ack, d_rdata=0, busy=0.
//  LAT=1 rebuild: single load completes with ack at cycle 3; concurrent-ack/strobe exclusivity checked every cycle.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - shares the single-port main memory between instruction fetch and load/store
// Each access runs setup, LAT strobe cycles, then a one-cycle ack; data has priority, limited by a streak counter.
module mem_access_sequencer #(
   parameter int AW           = 9,
   parameter int LAT          = 2,
   parameter int MAX_D_STREAK = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   output logic [31:0]   if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [31:0]   d_wdata,
   output logic          d_ack,
   output logic [31:0]   d_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic          mem_rd,
   output logic          mem_wr,
   input  logic [31:0]   mem_rdata,
   output logic          busy
);

   localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
   localparam int SW = $clog2(MAX_D_STREAK + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [SW-1:0] streak;
   logic          owner_d;
   logic          we_q;
   logic          fetch_wins;

   // Data normally wins; a pending fetch is forced through once data has had its full streak.
   assign fetch_wins = if_req && (!d_req || (streak == SW'(MAX_D_STREAK)));
   assign busy       = (state != S_IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         streak    <= '0;
         owner_d   <= 1'b0;
         we_q      <= 1'b0;
         if_ack    <= 1'b0;
         d_ack     <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (fetch_wins) begin
                  owner_d  <= 1'b0;
                  we_q     <= 1'b0;
                  mem_addr <= if_addr;
                  streak   <= '0;
                  state    <= S_SETUP;
               end else if (d_req) begin
                  owner_d   <= 1'b1;
                  we_q      <= d_we;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
                  if (!if_req)
                     streak <= '0;
                  else if (streak != SW'(MAX_D_STREAK))
                     streak <= streak + 1'b1;
                  state     <= S_SETUP;
               end
            end
            S_SETUP: begin
               mem_rd <= ~we_q;
               mem_wr <= we_q;
               cnt    <= CW'(LAT - 1);
               state  <= S_ACCESS;
            end
            S_ACCESS: begin
               if (cnt == '0) begin
                  mem_rd <= 1'b0;
                  mem_wr <= 1'b0;
                  if (owner_d) d_ack  <= 1'b1;
                  else         if_ack <= 1'b1;
                  // Read data is captured on the edge leaving the strobe window.
                  if (!we_q) begin
                     if (owner_d) d_rdata  <= mem_rdata;
                     else         if_rdata <= mem_rdata;
                  end
                  state <= S_DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_DONE: begin
               if_ack <= 1'b0;
               d_ack  <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb/tb_mem_access_sequencer.sv - directed vector bench for mem_access_sequencer (LAT=2 and LAT=1 builds)
module tb_mem_access_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        if_req, d_req, d_we;
   logic [8:0]  if_addr, d_addr;
   logic [31:0] d_wdata;
   logic        if_ack, d_ack, mem_rd, mem_wr, busy;
   logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
   logic [8:0]  mem_addr;

   logic        l1_if_req, l1_d_req, l1_d_we;
   logic [8:0]  l1_if_addr, l1_d_addr;
   logic [31:0] l1_d_wdata;
   logic        l1_if_ack, l1_d_ack, l1_mem_rd, l1_mem_wr, l1_busy;
   logic [31:0] l1_if_rdata, l1_d_rdata, l1_mem_wdata, l1_mem_rdata;
   logic [8:0]  l1_mem_addr;

   logic [31:0] ram [512];
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clock = ~clock;

   mem_access_sequencer #(.AW(9), .LAT(2), .MAX_D_STREAK(4)) dut (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_access_sequencer #(.AW(9), .LAT(1), .MAX_D_STREAK(4)) dut_l1 (
      .clock(clock), .reset(reset),
      .if_req(l1_if_req), .if_addr(l1_if_addr), .if_ack(l1_if_ack), .if_rdata(l1_if_rdata),
      .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
      .d_ack(l1_d_ack), .d_rdata(l1_d_rdata),
      .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata), .mem_rd(l1_mem_rd), .mem_wr(l1_mem_wr),
      .mem_rdata(l1_mem_rdata), .busy(l1_busy)
   );

   // RAM model: preloaded while reset is high, written on every cycle the write strobe is high.
   always @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 512; i++) ram[i] <= 32'h0;
         ram[9'h010] <= 32'hDEADBEEF;
         ram[9'h1FF] <= 32'hA5A55A5A;
      end else if (mem_wr) begin
         ram[mem_addr] <= mem_wdata;
      end
   end
   assign mem_rdata    = ram[mem_addr];
   assign l1_mem_rdata = 32'hC0DE0000 | {23'h0, l1_mem_addr};

   typedef struct {
      bit          own_d;
      bit          we;
      logic [8:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_if;
      logic [31:0] exp_d;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Every sampled cycle also checks that strobes and acks are mutually exclusive in both builds.
   task automatic nclk();
      @(negedge clock);
      check("exclusive_lat2", 128'($countones({mem_rd, mem_wr, if_ack, d_ack}) <= 1), 128'(1));
      check("exclusive_lat1", 128'($countones({l1_mem_rd, l1_mem_wr, l1_if_ack, l1_d_ack}) <= 1), 128'(1));
   endtask

   task automatic pedge();
      @(posedge clock);
      #1;
   endtask

   task automatic run_txn(input vec_t v, output int ack_cyc, output int rd_mask, output int wr_mask,
                          output logic [8:0] addr_seen, output logic [31:0] wdata_seen,
                          output logic busy5, output int other_ack);
      ack_cyc = -1; rd_mask = 0; wr_mask = 0; other_ack = 0;
      addr_seen = '0; wdata_seen = '0; busy5 = 1'b1;
      if (v.own_d) begin
         d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      for (int c = 0; c < 6; c++) begin
         nclk();
         if (mem_rd) rd_mask |= (1 << c);
         if (mem_wr) wr_mask |= (1 << c);
         if (mem_rd || mem_wr) begin addr_seen = mem_addr; wdata_seen = mem_wdata; end
         if ((v.own_d ? d_ack : if_ack) && ack_cyc < 0) ack_cyc = c;
         if (v.own_d ? if_ack : d_ack) other_ack++;
         if (c == 5) busy5 = busy;
         pedge();
         if (c == 0) begin
            // Inputs scrambled after the grant must not affect the transaction.
            if_addr = ~v.addr; d_addr = ~v.addr; d_wdata = ~v.wdata; d_we = ~v.we;
         end
         if (ack_cyc == c) begin d_req = 1'b0; if_req = 1'b0; end
      end
      if (ack_cyc < 0) begin
         d_req = 1'b0; if_req = 1'b0;
         repeat (8) pedge();
      end
   endtask

   initial begin
      int          ack_cyc, rd_mask, wr_mask, other_ack, dc, ic, n;
      logic [8:0]  addr_seen;
      logic [31:0] wdata_seen;
      logic        busy5, b5;
      logic [9:0]  seq;

      vecs[0] = '{1'b0, 1'b0, 9'h010, 32'h0,        32'hDEADBEEF, 32'h0};
      vecs[1] = '{1'b1, 1'b1, 9'h020, 32'h12345678, 32'hDEADBEEF, 32'h0};
      vecs[2] = '{1'b1, 1'b0, 9'h020, 32'h0,        32'hDEADBEEF, 32'h12345678};
      vecs[3] = '{1'b1, 1'b0, 9'h1FF, 32'h0,        32'hDEADBEEF, 32'hA5A55A5A};
      vecs[4] = '{1'b1, 1'b1, 9'h000, 32'hFFFFFFFF, 32'hDEADBEEF, 32'hA5A55A5A};
      vecs[5] = '{1'b0, 1'b0, 9'h000, 32'h0,        32'hFFFFFFFF, 32'hA5A55A5A};
      vecs[6] = '{1'b1, 1'b1, 9'h1FF, 32'h0F0F0F0F, 32'hFFFFFFFF, 32'hA5A55A5A};
      vecs[7] = '{1'b1, 1'b0, 9'h1FF, 32'h0,        32'hFFFFFFFF, 32'h0F0F0F0F};

      reset = 1'b1;
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; if_addr = '0; d_addr = '0; d_wdata = '0;
      l1_if_req = 1'b0; l1_d_req = 1'b0; l1_d_we = 1'b0;
      l1_if_addr = '0; l1_d_addr = '0; l1_d_wdata = '0;
      repeat (3) pedge();
      reset = 1'b0;

      nclk();
      check("reset_outputs", {mem_rd, mem_wr, if_ack, d_ack, busy, if_rdata, d_rdata, mem_addr, mem_wdata}, '0);
      check("reset_outputs_lat1", {l1_mem_rd, l1_mem_wr, l1_if_ack, l1_d_ack, l1_busy,
                                   l1_if_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata}, '0);
      pedge();

      for (int i = 0; i < 8; i++) begin
         run_txn(vecs[i], ack_cyc, rd_mask, wr_mask, addr_seen, wdata_seen, busy5, other_ack);
         check($sformatf("v%0d_ack_cycle", i), 128'(ack_cyc), 128'(4));
         check($sformatf("v%0d_rd_cycles", i), 128'(rd_mask), vecs[i].we ? 128'(0) : 128'(12));
         check($sformatf("v%0d_wr_cycles", i), 128'(wr_mask), vecs[i].we ? 128'(12) : 128'(0));
         check($sformatf("v%0d_mem_addr", i), 128'(addr_seen), 128'(vecs[i].addr));
         if (vecs[i].we) check($sformatf("v%0d_mem_wdata", i), 128'(wdata_seen), 128'(vecs[i].wdata));
         check($sformatf("v%0d_if_rdata", i), 128'(if_rdata), 128'(vecs[i].exp_if));
         check($sformatf("v%0d_d_rdata", i), 128'(d_rdata), 128'(vecs[i].exp_d));
         check($sformatf("v%0d_idle_after", i), 128'(busy5), 128'(0));
         check($sformatf("v%0d_wrong_ack", i), 128'(other_ack), 128'(0));
      end

      // Simultaneous requests: data first, fetch granted in the following idle cycle.
      dc = -1; ic = -1; b5 = 1'b1;
      d_req = 1'b1; d_we = 1'b0; d_addr = 9'h020; if_req = 1'b1; if_addr = 9'h010;
      for (int c = 0; c < 15; c++) begin
         nclk();
         if (d_ack && dc < 0) dc = c;
         if (if_ack && ic < 0) ic = c;
         if (c == 5) b5 = busy;
         pedge();
         if (dc == c) d_req = 1'b0;
         if (ic == c) if_req = 1'b0;
      end
      d_req = 1'b0; if_req = 1'b0;
      check("both_d_ack_cycle", 128'(dc), 128'(4));
      check("both_if_ack_cycle", 128'(ic), 128'(9));
      check("both_idle_at_5", 128'(b5), 128'(0));
      check("both_d_rdata", 128'(d_rdata), 128'(32'h12345678));
      check("both_if_rdata", 128'(if_rdata), 128'(32'hDEADBEEF));

      // Both requesters held: four data grants, then one forced fetch, repeating.
      n = 0; seq = '0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 9'h010; if_req = 1'b1; if_addr = 9'h020;
      for (int c = 0; c < 120 && n < 10; c++) begin
         nclk();
         if (d_ack) begin seq[n] = 1'b1; n++; end
         else if (if_ack) begin seq[n] = 1'b0; n++; end
         pedge();
      end
      d_req = 1'b0; if_req = 1'b0;
      check("streak_ack_count", 128'(n), 128'(10));
      check("streak_pattern", 128'(seq), 128'(10'b0111101111));
      repeat (4) pedge();

      // Reset during the strobe window of a load aborts it.
      d_req = 1'b1; d_we = 1'b0; d_addr = 9'h1FF;
      nclk(); pedge();
      nclk(); pedge();
      nclk();
      check("abort_rd_in_access", 128'(mem_rd), 128'(1));
      reset = 1'b1; d_req = 1'b0;
      pedge();
      reset = 1'b0;
      nclk();
      check("abort_strobes", 128'({mem_rd, mem_wr}), 128'(0));
      check("abort_no_ack", 128'({if_ack, d_ack}), 128'(0));
      check("abort_d_rdata", 128'(d_rdata), 128'(0));
      check("abort_busy", 128'(busy), 128'(0));
      pedge();
      nclk();
      check("abort_stays_idle", 128'({busy, d_ack}), 128'(0));
      pedge();

      // LAT=1 build: single load acks at cycle 3 with one strobe cycle.
      ack_cyc = -1; rd_mask = 0;
      l1_d_req = 1'b1; l1_d_we = 1'b0; l1_d_addr = 9'h033;
      for (int c = 0; c < 6; c++) begin
         nclk();
         if (l1_mem_rd) rd_mask |= (1 << c);
         if (l1_d_ack && ack_cyc < 0) ack_cyc = c;
         pedge();
         if (ack_cyc == c) l1_d_req = 1'b0;
      end
      l1_d_req = 1'b0;
      check("lat1_ack_cycle", 128'(ack_cyc), 128'(3));
      check("lat1_rd_cycles", 128'(rd_mask), 128'(4));
      check("lat1_d_rdata", 128'(l1_d_rdata), 128'(32'hC0DE0033));
      check("lat1_idle", 128'(l1_busy), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
